// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the shift_serializer block: FSM state encodings and
// the state enum type used by the top-level controller.
//
// Configuration macro: SHIFT_SERIALIZER_PARITY_EN
//   defined   -> the PARITY state exists (one even-parity bit per word)
//   undefined -> only IDLE and SHIFT exist
// -----------------------------------------------------------------------------
package shift_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;

`ifdef SHIFT_SERIALIZER_PARITY_EN
  localparam logic [1:0] ST_PARITY = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_SHIFT  = ST_SHIFT,
    S_PARITY = ST_PARITY
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT
  } state_e;
`endif

endpackage

// File: rtl/shift_serializer_if.sv
// -----------------------------------------------------------------------------
// shift_serializer_if
// Bundles the parallel-load handshake and the serial output of shift_serializer.
//
// Signals:
//   i_data       WIDTH  parallel word to serialize
//   i_valid      1      i_data is valid for transfer
//   o_ready      1      serializer accepts a word this cycle
//   i_shift_en   1      bit-advance enable (low stalls the stream)
//   o_dout       1      serial data bit
//   o_dout_valid 1      qualifies o_dout
//   o_last       1      marks the final serial bit of a word
//
// Modports:
//   master -> word producer / serial consumer (drives i_*)
//   slave  -> the serializer (drives o_*)
// -----------------------------------------------------------------------------
interface shift_serializer_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] i_data;
  logic             i_valid;
  logic             o_ready;
  logic             i_shift_en;
  logic             o_dout;
  logic             o_dout_valid;
  logic             o_last;

  modport master (
    output i_data,
    output i_valid,
    output i_shift_en,
    input  o_ready,
    input  o_dout,
    input  o_dout_valid,
    input  o_last
  );

  modport slave (
    input  i_data,
    input  i_valid,
    input  i_shift_en,
    output o_ready,
    output o_dout,
    output o_dout_valid,
    output o_last
  );

endinterface

// File: rtl/shift_bit_counter.sv
// -----------------------------------------------------------------------------
// shift_bit_counter
// Down-counter tracking which data bit is currently on the serial output.
// Loads WIDTH-1 on word acceptance and decrements on each enabled advance,
// saturating at zero (never wraps).
//
// Ports:
//   i_clk    1   clock, rising edge
//   i_rst    1   asynchronous active-high reset (count -> 0)
//   i_load   1   load WIDTH-1 (has priority over i_en)
//   i_en     1   decrement by one if not already zero
//   o_count  CW  current count, CW = $clog2(WIDTH+1)
//   o_zero   1   count is zero
// -----------------------------------------------------------------------------
module shift_bit_counter #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic          i_en,
  output logic [CW-1:0] o_count,
  output logic          o_zero
);

  logic [CW-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= CW'(WIDTH - 1);
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/shift_serializer.sv
// -----------------------------------------------------------------------------
// shift_serializer
// Parallel-to-serial converter, MSB first. A word is accepted when i_valid and
// o_ready are both high at a rising edge; its MSB appears on o_dout one cycle
// later. Each cycle with i_shift_en high advances one bit; o_last flags the
// final bit, during which a new word may be accepted for gap-free streaming.
//
// Ports:
//   i_clk   1   clock, rising edge
//   i_rst   1   asynchronous active-high reset; aborts any word in progress
//   bus     shift_serializer_if.slave (i_data, i_valid, o_ready, i_shift_en,
//           o_dout, o_dout_valid, o_last)
//
// Configuration macro: SHIFT_SERIALIZER_PARITY_EN
//   When defined, an even-parity bit (XOR of all data bits) follows bit 0 in
//   state PARITY and carries o_last. When undefined, no parity logic exists
//   and a word is exactly WIDTH serial bits.
// -----------------------------------------------------------------------------
module shift_serializer
  import shift_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  shift_serializer_if.slave   bus
);

  state_e         r_state;
  logic [WIDTH-1:0] r_shreg;   // current bit always sits at the MSB
  logic           r_dout;
  logic           r_dout_valid;
  logic           r_last;
`ifdef SHIFT_SERIALIZER_PARITY_EN
  logic           r_parity;
`endif

  logic           w_ready;
  logic           w_accept;
  logic           w_advance;
  logic           w_cnt_en;
  logic [CW-1:0]  w_count;
  logic           w_zero;

  // Ready in IDLE, or while the final bit is being advanced out this cycle.
  assign w_ready   = (r_state == S_IDLE) || (r_last && bus.i_shift_en);
  assign w_accept  = bus.i_valid && w_ready;
  assign w_advance = bus.i_shift_en && (r_state != S_IDLE);
  assign w_cnt_en  = w_advance && (r_state == S_SHIFT);

  shift_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_accept),
    .i_en    (w_cnt_en),
    .o_count (w_count),
    .o_zero  (w_zero)
  );

  // NOTE: the shift register is reset along with the control state so no bit
  // of an aborted word can ever reappear on o_dout.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_shreg      <= '0;
      r_dout       <= 1'b0;
      r_dout_valid <= 1'b0;
      r_last       <= 1'b0;
`ifdef SHIFT_SERIALIZER_PARITY_EN
      r_parity     <= 1'b0;
`endif
    end else if (w_accept) begin
      // Load takes priority: in the final-bit cycle this gives back-to-back words.
      r_state      <= S_SHIFT;
      r_shreg      <= bus.i_data;
      r_dout       <= bus.i_data[WIDTH-1];
      r_dout_valid <= 1'b1;
      r_last       <= 1'b0;
`ifdef SHIFT_SERIALIZER_PARITY_EN
      r_parity     <= ^bus.i_data;
`endif
    end else if (w_advance) begin
      case (r_state)
        S_SHIFT: begin
          if (!w_zero) begin
            r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
            r_dout  <= r_shreg[WIDTH-2];
`ifdef SHIFT_SERIALIZER_PARITY_EN
            r_last  <= 1'b0;
`else
            // Next bit is bit 0 when the counter is about to reach zero.
            r_last  <= (w_count == CW'(1));
`endif
          end else begin
`ifdef SHIFT_SERIALIZER_PARITY_EN
            r_state <= S_PARITY;
            r_dout  <= r_parity;
            r_last  <= 1'b1;
`else
            r_state      <= S_IDLE;
            r_shreg      <= '0;
            r_dout       <= 1'b0;
            r_dout_valid <= 1'b0;
            r_last       <= 1'b0;
`endif
          end
        end
        default: begin
          // Final (parity) bit advanced with no new word: back to IDLE.
          r_state      <= S_IDLE;
          r_shreg      <= '0;
          r_dout       <= 1'b0;
          r_dout_valid <= 1'b0;
          r_last       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_ready      = w_ready;
  assign bus.o_dout       = r_dout;
  assign bus.o_dout_valid = r_dout_valid;
  assign bus.o_last       = r_last;

endmodule

// File: doc/shift_serializer.md
SHIFT_SERIALIZER -- requirements
Module: shift_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the parallel word width in bits (legal range 2..64).
REQ-002 SHALL have port i_clk  input  1  as the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst  input  1  as the reset, asynchronous and active-high.
REQ-004 SHALL have port i_data  input  WIDTH  as the parallel word to serialize.
REQ-005 SHALL have port i_valid  input  1  to indicate i_data is valid for transfer.
REQ-006 SHALL have port o_ready  output  1  to indicate the block accepts a word this cycle.
REQ-007 SHALL have port i_shift_en  input  1  as the bit-advance enable; low stalls the serial stream.
REQ-008 SHALL have port o_dout  output  1  as the serial data bit.
REQ-009 SHALL have port o_dout_valid  output  1  to qualify o_dout.
REQ-010 SHALL have port o_last  output  1  to mark the final serial bit of a word.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT and PARITY; PARITY exists only per REQ-024.
REQ-012 SHALL accept a word when i_valid and o_ready are both high at a rising edge; no other condition loads i_data.
REQ-013 SHALL drive o_ready high in IDLE, and in the final-bit cycle (o_last high) when i_shift_en is high; low otherwise.
REQ-014 SHALL, on acceptance, present i_data[WIDTH-1] on o_dout with o_dout_valid high in the next cycle (latency 1).
REQ-015 SHALL shift MSB first: each cycle with i_shift_en high advances to the next lower bit, ending with bit 0.
REQ-016 SHALL hold o_dout, o_dout_valid, o_last and the bit counter unchanged while i_shift_en is low, in any state.
REQ-017 SHALL assert o_last together with the final bit of each word (bit 0, or the parity bit per REQ-024).
REQ-018 SHALL, when a new word is accepted during the final-bit cycle, emit its MSB in the following cycle with no gap (back-to-back streaming).
REQ-019 SHALL return to IDLE after the final bit advances with no new word accepted; o_dout_valid, o_last and o_dout go to 0.
REQ-020 SHALL ignore i_valid while o_ready is low; i_data is not captured and the current word is not disturbed.
REQ-021 SHALL use a bit counter of width $clog2(WIDTH+1), counting down from WIDTH-1; no wrap-around past 0.

Reset
REQ-022 SHALL, while i_rst is high, force state IDLE, shift register 0, counter 0, o_dout 0, o_dout_valid 0, o_last 0; o_ready is 1.
REQ-023 SHALL abort any word in progress on reset assertion; the partial word is discarded and never resumes.

Configuration
REQ-024 SHALL, with SHIFT_SERIALIZER_PARITY_EN defined, append one even-parity bit (XOR of all WIDTH data bits) after bit 0 in state PARITY; o_last is on the parity bit, and o_ready follows REQ-013 during that cycle.
REQ-025 SHALL, without SHIFT_SERIALIZER_PARITY_EN, contain no PARITY state or parity logic; a word is exactly WIDTH serial bits.

Structure
REQ-026 SHALL take the FSM state enum type and the state encodings from shared package shift_pkg.
REQ-027 SHALL place the down-counter (load, enable, zero flag) in sub-module shift_bit_counter, parameterized by WIDTH.

Verification
REQ-028 SHALL cover single word: WIDTH=8, accept 0xA5 -> o_dout 1,0,1,0,0,1,0,1 on cycles 1..8 after acceptance, o_last on cycle 8, then IDLE.
REQ-029 SHALL cover back-to-back: 0xA5 then 0x3C held valid -> 16 contiguous valid bits, o_last on bits 8 and 16, no idle cycle between words.
REQ-030 SHALL cover stall: i_shift_en low 3 cycles after bit 4 of 0xA5 -> o_dout holds 0 for 3 extra cycles, then sequence resumes correctly.
REQ-031 SHALL cover reset mid-word: i_rst pulsed at bit 5 of 0xFF -> all outputs 0 and o_ready 1 immediately; next word 0x81 serializes as 1,0,0,0,0,0,0,1.
REQ-032 SHALL cover busy-ignore: i_valid with 0x55 at bit 3 of 0xA5 -> 0x55 not captured; 0xA5 completes unchanged.
REQ-033 SHALL cover parity (macro defined): 0xA5 -> 9th bit 0 with o_last; 0x07 -> 9th bit 1 with o_last.
